// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared constants, state encoding and rotate helper for the round-robin arbiter
package rr_arbiter8_pkg;

    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Rotate right so that result bit j is v[(j + s) mod 8]; bit 0 is the requester at s.
    function automatic logic [N_REQ-1:0] rotr8(input logic [N_REQ-1:0] v, input logic [IDX_W-1:0] s);
        logic [2*N_REQ-1:0] d;
        d = {v, v} >> s;
        return d[N_REQ-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter8_pri_enc8_lo.sv
// pri_enc8_lo: combinational 8-bit priority encoder, lowest set bit wins
//   vec   : input vector
//   idx   : index of lowest set bit (0 when none)
//   valid : at least one bit of vec is set
module pri_enc8_lo
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = |vec;
        // Descending scan so the lowest set bit is written last and wins.
        for (int i = N_REQ - 1; i >= 0; i--)
            if (vec[i]) idx = IDX_W'(i);
    end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-requester round-robin arbiter with MAX_HOLD forced rotation and registered outputs
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   req       : request vector, bit i is requester i
//   gnt       : one-hot grant, zero when idle
//   gnt_idx   : binary index of the owner, zero when idle
//   gnt_valid : a grant is active
//   rot       : one-cycle pulse when the grant moved because of the hold timeout
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             rot
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [7:0]       hold_cnt, hold_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             valid_nxt;
    logic             rot_nxt;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;
    logic [IDX_W-1:0] sel_idx;
    logic             keep;
    logic             last;
    logic             others;

    pri_enc8_lo u_enc (
        .vec   (rotr8(req, ptr)),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // The encoder sees requests relative to ptr; add ptr back to get the absolute index.
    assign sel_idx = enc_idx + ptr;
    assign keep    = (state == GRANT) && req[gnt_idx];
    assign last    = hold_cnt == HOLD_LAST;
    assign others  = |(req & ~gnt);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        idx_nxt   = gnt_idx;
        valid_nxt = gnt_valid;
        rot_nxt   = 1'b0;
        if (state == IDLE || !keep || (last && others)) begin
            // New selection: from idle, on release, or on timeout with another requester.
            // Searching from owner+1 reaches any other requester before the owner itself.
            if (enc_valid) begin
                state_nxt = GRANT;
                idx_nxt   = sel_idx;
                ptr_nxt   = sel_idx + 3'd1;
                hold_nxt  = '0;
                valid_nxt = 1'b1;
                rot_nxt   = keep;
            end else begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                hold_nxt  = '0;
                valid_nxt = 1'b0;
            end
        end else begin
            // Owner keeps the grant; a lone owner at timeout just restarts its window.
            hold_nxt = last ? 8'd0 : hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            rot       <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt       <= valid_nxt ? N_REQ'(1) << idx_nxt : '0;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            rot       <= rot_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: randomized self-checking bench for rr_arbiter8 against a behavioural model
module tb_rr_arbiter8;

    localparam int MH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       rot;
    logic [12:0] obs;

    int checks = 0;
    int failures = 0;

    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_rot;

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .rot       (rot)
    );

    always #5 clk = ~clk;

    assign obs = {gnt, gnt_idx, gnt_valid, rot};

    function automatic logic [12:0] exp_vec();
        logic [7:0] g;
        logic [2:0] i;
        g = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        i = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        return {g, i, m_owner >= 0, m_rot};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_rot   = 0;
    endtask

    task automatic model_edge(input logic [7:0] r);
        int sel;
        sel = -1;
        for (int k = 0; k < 8; k++)
            if (sel < 0 && r[(m_ptr + k) % 8]) sel = (m_ptr + k) % 8;
        m_rot = 0;
        if (m_owner >= 0 && r[m_owner] && !(m_hold == MH - 1 && (r & ~8'(1 << m_owner)) != 0)) begin
            m_hold = (m_hold == MH - 1) ? 0 : m_hold + 1;
        end else if (sel >= 0) begin
            m_rot   = (m_owner >= 0) && r[m_owner];
            m_owner = sel;
            m_ptr   = (sel + 1) % 8;
            m_hold  = 0;
        end else begin
            m_owner = -1;
            m_hold  = 0;
        end
    endtask

    task automatic tick(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 13'd0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", obs, 13'd0);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(8'h00);
            checks++;
            if (obs !== 13'd0 || obs !== exp_vec()) begin
                failures++;
                $display("FAIL idle_no_req cyc=%0d got=%h exp=%h", c, obs, 13'd0);
            end
        end
    endtask

    task automatic test_rotation();
        logic [7:0] r;
        for (int i = 0; i < 9; i++) begin
            r = (m_owner >= 0) ? (8'hFF & ~8'(1 << m_owner)) : 8'hFF;
            tick(r);
            checks++;
            if (obs !== exp_vec() || gnt_idx !== 3'(i % 8) || !gnt_valid || rot !== 1'b0) begin
                failures++;
                $display("FAIL rotation step=%0d got=%h exp=%h idx_exp=%0d", i, obs, exp_vec(), i % 8);
            end
        end
    endtask

    task automatic test_timeout();
        tick(8'h00);
        tick(8'h08);
        checks++;
        if (obs !== exp_vec() || gnt !== 8'h08) begin
            failures++;
            $display("FAIL timeout_start got=%h exp=%h", obs, exp_vec());
        end
        for (int c = 0; c < 15; c++) begin
            tick(8'h28);
            checks++;
            if (obs !== exp_vec() || gnt !== 8'h08 || rot !== 1'b0) begin
                failures++;
                $display("FAIL timeout_hold cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
        end
        tick(8'h28);
        checks++;
        if (obs !== exp_vec() || gnt !== 8'h20 || rot !== 1'b1) begin
            failures++;
            $display("FAIL timeout_rotate got=%h exp=%h", obs, exp_vec());
        end
        tick(8'h28);
        checks++;
        if (obs !== exp_vec() || gnt !== 8'h20 || rot !== 1'b0) begin
            failures++;
            $display("FAIL timeout_rot_pulse got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_single_hold();
        for (int c = 0; c < 40; c++) begin
            tick(8'h40);
            checks++;
            if (obs !== exp_vec() || gnt !== 8'h40 || rot !== 1'b0) begin
                failures++;
                $display("FAIL single_hold cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_release_wrap();
        tick(8'h00);
        tick(8'h04);
        checks++;
        if (obs !== exp_vec() || gnt !== 8'h04) begin
            failures++;
            $display("FAIL wrap_owner2 got=%h exp=%h", obs, exp_vec());
        end
        tick(8'h03);
        checks++;
        if (obs !== exp_vec() || gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            failures++;
            $display("FAIL wrap_next got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_async_reset();
        tick(8'h00);
        tick(8'h20);
        checks++;
        if (obs !== exp_vec() || gnt !== 8'h20) begin
            failures++;
            $display("FAIL areset_owner5 got=%h exp=%h", obs, exp_vec());
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs !== 13'd0) begin
            failures++;
            $display("FAIL areset_immediate got=%h exp=%h", obs, 13'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(8'h21);
        checks++;
        if (obs !== exp_vec() || gnt !== 8'h01) begin
            failures++;
            $display("FAIL areset_first got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        int bad;
        r = 8'h00;
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 31) == 0) r = 8'($urandom);
            else if ($urandom_range(0, 15) == 0) r = r ^ 8'(1 << $urandom_range(0, 7));
            tick(r);
            checks++;
            if (obs !== exp_vec() || $countones(gnt) > 1) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cyc=%0d req=%h got=%h exp=%h", c, r, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_timeout();
        test_single_hold();
        test_release_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
